ecc_scrub_pacer: RTL and testbench

Pacing and error-accounting stage for the data-cache ECC scrubber. It generates the scrubber's level-sensitive scrub trigger as a programmable burst/idle duty cycle, and consumes the scrubber's per-step `bit_corrected` / `uncorrectable` pulses. It accumulates those pulses into saturating counters and raises a sticky interrupt for the core. It sits between the cache CSR/control logic and the scrubber instance.

---
 rtl/ecc_scrub_pacer.sv | 206 ++++++++++++++++++++
 tb/tb_ecc_scrub_pacer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_scrub_pacer.sv
// ---------------------------------------------------------------------------
// ecc_scrub_pacer
//
// Pacing and error-accounting stage for the data-cache ECC scrubber.
// - Generates a registered, level-sensitive scrub trigger. The trigger
//   follows a programmable duty cycle: burst_len_i cycles high, then
//   interval_i cycles low. An interval of 0 keeps the trigger high.
// - Counts the scrubber's corrected and uncorrectable pulses in saturating
//   counters.
// - Raises a sticky interrupt.
// - Optionally logs the location of the last uncorrectable error.
//
// Optional feature macro: ECC_SCRUB_PACER_LOG_EN
//   Defined   -> the last-uncorrectable-error log registers are built.
//   Undefined -> log_valid_o, log_add_o and log_way_o are tied to 0.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   enable_i         pacing enable
//   interval_i       trigger-low cycles between bursts (0 = continuous)
//   burst_len_i      trigger-high cycles per burst (0 treated as 1)
//   scrub_trigger_o  registered level trigger to the scrubber
//   bit_corrected_i  single-cycle corrected-error pulse
//   uncorrectable_i  single-cycle uncorrectable-error pulse
//   err_add_i        scrubber set address, valid with the pulses
//   err_way_i        scrubber way, valid with the pulses
//   clear_i          synchronous clear of counters, interrupt and log
//   corr_threshold_i correctable-error irq threshold (0 = disabled)
//   corr_cnt_o       corrected-error count (saturating)
//   uncorr_cnt_o     uncorrectable-error count (saturating)
//   irq_o            sticky interrupt
//   log_valid_o      a last uncorrectable error has been captured
//   log_add_o        address of the last uncorrectable error
//   log_way_o        way of the last uncorrectable error
// ---------------------------------------------------------------------------
module ecc_scrub_pacer #(
    parameter int AddrWidth  = 8,
    parameter int WayWidth   = 1,
    parameter int CntWidth   = 16,
    parameter int TimerWidth = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic [TimerWidth-1:0] interval_i,
    input  logic [TimerWidth-1:0] burst_len_i,
    output logic                  scrub_trigger_o,
    input  logic                  bit_corrected_i,
    input  logic                  uncorrectable_i,
    input  logic [AddrWidth-1:0]  err_add_i,
    input  logic [WayWidth-1:0]   err_way_i,
    input  logic                  clear_i,
    input  logic [CntWidth-1:0]   corr_threshold_i,
    output logic [CntWidth-1:0]   corr_cnt_o,
    output logic [CntWidth-1:0]   uncorr_cnt_o,
    output logic                  irq_o,
    output logic                  log_valid_o,
    output logic [AddrWidth-1:0]  log_add_o,
    output logic [WayWidth-1:0]   log_way_o
);

    localparam logic [0:0] StWait  = 1'b0;
    localparam logic [0:0] StBurst = 1'b1;

    localparam logic [TimerWidth-1:0] TimerZero = '0;
    localparam logic [TimerWidth-1:0] TimerOne  = {{(TimerWidth-1){1'b0}}, 1'b1};
    localparam logic [CntWidth-1:0]   CntZero   = '0;
    localparam logic [CntWidth-1:0]   CntOne    = {{(CntWidth-1){1'b0}}, 1'b1};
    localparam logic [CntWidth-1:0]   CntMax    = '1;

    logic [0:0]            state_q, state_d;
    logic [TimerWidth-1:0] cnt_q, cnt_d;
    logic [TimerWidth-1:0] burst_last;
    logic [TimerWidth-1:0] wait_last;

    logic [CntWidth-1:0]   corr_q, corr_base, corr_d;
    logic [CntWidth-1:0]   uncorr_q, uncorr_base, uncorr_d;
    logic                  irq_q, irq_d;

    // Last cnt value of each phase. A burst length of 0 is treated as 1,
    // so its last index is 0. wait_last is only used when interval_i != 0.
    assign burst_last = (burst_len_i == TimerZero) ? TimerZero : burst_len_i - TimerOne;
    assign wait_last  = interval_i - TimerOne;

    // Next-state logic for the burst/idle duty cycle.
    // WAIT ends on an equality compare.
    // BURST ends on >=, so a burst length lowered mid-burst takes effect
    // at the next edge instead of wrapping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!enable_i) begin
            state_d = StWait;
            cnt_d   = TimerZero;
        end else if (state_q == StWait) begin
            if (interval_i == TimerZero || cnt_q == wait_last) begin
                state_d = StBurst;
                cnt_d   = TimerZero;
            end else begin
                cnt_d = cnt_q + TimerOne;
            end
        end else begin
            if (interval_i == TimerZero) begin
                state_d = StBurst;
                cnt_d   = TimerZero;
            end else if (cnt_q >= burst_last) begin
                state_d = StWait;
                cnt_d   = TimerZero;
            end else begin
                cnt_d = cnt_q + TimerOne;
            end
        end
    end

    // FSM state and phase counter.
    // The trigger comes straight from the state flop, so reset drops it
    // asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StWait;
            cnt_q   <= TimerZero;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign scrub_trigger_o = (state_q == StBurst);

    // Error accounting.
    // The clear is applied first, then the same-cycle events. A pulse that
    // coincides with a clear therefore leaves its counter at 1.
    // The threshold compare uses the post-update value, so the irq rises in
    // the same cycle as the counter reaches the threshold.
    always_comb begin
        corr_base   = clear_i ? CntZero : corr_q;
        uncorr_base = clear_i ? CntZero : uncorr_q;
        corr_d      = corr_base;
        uncorr_d    = uncorr_base;
        if (bit_corrected_i && corr_base != CntMax) begin
            corr_d = corr_base + CntOne;
        end
        if (uncorrectable_i && uncorr_base != CntMax) begin
            uncorr_d = uncorr_base + CntOne;
        end
        irq_d = (clear_i ? 1'b0 : irq_q)
              | uncorrectable_i
              | ((corr_threshold_i != CntZero) && (corr_d == corr_threshold_i));
    end

    // Counter and interrupt registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            corr_q   <= CntZero;
            uncorr_q <= CntZero;
            irq_q    <= 1'b0;
        end else begin
            corr_q   <= corr_d;
            uncorr_q <= uncorr_d;
            irq_q    <= irq_d;
        end
    end

    assign corr_cnt_o   = corr_q;
    assign uncorr_cnt_o = uncorr_q;
    assign irq_o        = irq_q;

`ifdef ECC_SCRUB_PACER_LOG_EN
    logic                 log_valid_q;
    logic [AddrWidth-1:0] log_add_q;
    logic [WayWidth-1:0]  log_way_q;

    // Last-error log.
    // A new uncorrectable error overwrites the previous capture. A
    // coincident clear is applied first, so the new error survives it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            log_valid_q <= 1'b0;
            log_add_q   <= '0;
            log_way_q   <= '0;
        end else if (uncorrectable_i) begin
            log_valid_q <= 1'b1;
            log_add_q   <= err_add_i;
            log_way_q   <= err_way_i;
        end else if (clear_i) begin
            log_valid_q <= 1'b0;
            log_add_q   <= '0;
            log_way_q   <= '0;
        end
    end

    assign log_valid_o = log_valid_q;
    assign log_add_o   = log_add_q;
    assign log_way_o   = log_way_q;
`else
    // Without the log, the error location inputs have no consumer.
    logic unused_log_inputs;
    assign unused_log_inputs = ^{err_add_i, err_way_i};

    assign log_valid_o = 1'b0;
    assign log_add_o   = '0;
    assign log_way_o   = '0;
`endif

endmodule

// File: tb/tb_ecc_scrub_pacer.sv
// ---------------------------------------------------------------------------
// tb_ecc_scrub_pacer
//
// Self-checking bench for ecc_scrub_pacer. The DUT is built with
// CntWidth = 4 and TimerWidth = 8.
//
// The reference model describes the trigger as a periodic waveform,
// indexed by the number of consecutive enabled edges. The error counters
// are kept as plain saturating integers.
//
// The expected log outputs follow ECC_SCRUB_PACER_LOG_EN.
// ---------------------------------------------------------------------------
module tb_ecc_scrub_pacer;

    localparam int AddrWidth  = 8;
    localparam int WayWidth   = 1;
    localparam int CntWidth   = 4;
    localparam int TimerWidth = 8;
    localparam int CntMaxInt  = (1 << CntWidth) - 1;

    logic                  clk_i;
    logic                  rst_i;
    logic                  enable_i;
    logic [TimerWidth-1:0] interval_i;
    logic [TimerWidth-1:0] burst_len_i;
    logic                  scrub_trigger_o;
    logic                  bit_corrected_i;
    logic                  uncorrectable_i;
    logic [AddrWidth-1:0]  err_add_i;
    logic [WayWidth-1:0]   err_way_i;
    logic                  clear_i;
    logic [CntWidth-1:0]   corr_threshold_i;
    logic [CntWidth-1:0]   corr_cnt_o;
    logic [CntWidth-1:0]   uncorr_cnt_o;
    logic                  irq_o;
    logic                  log_valid_o;
    logic [AddrWidth-1:0]  log_add_o;
    logic [WayWidth-1:0]   log_way_o;

    int compareCount = 0;
    int failCount    = 0;

    // Reference model state.
    int mEnRun;
    int mTrig;
    int mCorr;
    int mUncorr;
    int mIrq;
    int mLogValid;
    int mLogAdd;
    int mLogWay;

    ecc_scrub_pacer #(
        .AddrWidth (AddrWidth),
        .WayWidth  (WayWidth),
        .CntWidth  (CntWidth),
        .TimerWidth(TimerWidth)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .enable_i        (enable_i),
        .interval_i      (interval_i),
        .burst_len_i     (burst_len_i),
        .scrub_trigger_o (scrub_trigger_o),
        .bit_corrected_i (bit_corrected_i),
        .uncorrectable_i (uncorrectable_i),
        .err_add_i       (err_add_i),
        .err_way_i       (err_way_i),
        .clear_i         (clear_i),
        .corr_threshold_i(corr_threshold_i),
        .corr_cnt_o      (corr_cnt_o),
        .uncorr_cnt_o    (uncorr_cnt_o),
        .irq_o           (irq_o),
        .log_valid_o     (log_valid_o),
        .log_add_o       (log_add_o),
        .log_way_o       (log_way_o)
    );

    // Free-running clock, 10 time-unit period.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Clear every modelled output back to its reset value.
    task automatic modelReset();
        mEnRun    = 0;
        mTrig     = 0;
        mCorr     = 0;
        mUncorr   = 0;
        mIrq      = 0;
        mLogValid = 0;
        mLogAdd   = 0;
        mLogWay   = 0;
    endtask

    // Advance the model by one rising edge, using the inputs in force.
    //
    // mEnRun counts consecutive edges with the enable sampled high.
    // For interval n > 0 and burst bm, the trigger is low for the first
    // n-1 edges of a run. After that it repeats bm high edges followed by
    // n low edges.
    task automatic modelEdge(input int en, input int n, input int b,
                             input int bc, input int uc, input int add,
                             input int way, input int clr, input int thr);
        int bm;
        int period;
        bm = (b == 0) ? 1 : b;
        period = n + bm;
        if (en != 0) begin
            mEnRun = mEnRun + 1;
            if (n == 0) mTrig = 1;
            else if (mEnRun < n) mTrig = 0;
            else mTrig = (((mEnRun - n) % period) < bm) ? 1 : 0;
        end else begin
            mEnRun = 0;
            mTrig  = 0;
        end
        if (clr != 0) begin
            mCorr = 0; mUncorr = 0; mIrq = 0;
`ifdef ECC_SCRUB_PACER_LOG_EN
            mLogValid = 0; mLogAdd = 0; mLogWay = 0;
`endif
        end
        if (bc != 0 && mCorr < CntMaxInt) mCorr = mCorr + 1;
        if (uc != 0 && mUncorr < CntMaxInt) mUncorr = mUncorr + 1;
        if (uc != 0) begin
            mIrq = 1;
`ifdef ECC_SCRUB_PACER_LOG_EN
            mLogValid = 1; mLogAdd = add; mLogWay = way;
`endif
        end
        if (thr != 0 && mCorr == thr) mIrq = 1;
    endtask

    // Single comparison point.
    // Counts the comparison, and reports and counts any failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic checkAll(input string tag);
        checkOutput({tag, ".trigger"}, {31'd0, scrub_trigger_o}, mTrig);
        checkOutput({tag, ".corr"},    {28'd0, corr_cnt_o},      mCorr);
        checkOutput({tag, ".uncorr"},  {28'd0, uncorr_cnt_o},    mUncorr);
        checkOutput({tag, ".irq"},     {31'd0, irq_o},           mIrq);
        checkOutput({tag, ".logv"},    {31'd0, log_valid_o},     mLogValid);
        checkOutput({tag, ".loga"},    {24'd0, log_add_o},       mLogAdd);
        checkOutput({tag, ".logw"},    {31'd0, log_way_o},       mLogWay);
    endtask

    // Drive one cycle of inputs on the falling edge.
    // Then let the DUT and the model take the rising edge, and check the
    // outputs just after it.
    task automatic applyStimulus(input string tag, input int en, input int n,
                                 input int b, input int bc, input int uc,
                                 input int add, input int way, input int clr,
                                 input int thr);
        @(negedge clk_i);
        enable_i         = en[0];
        interval_i       = n[TimerWidth-1:0];
        burst_len_i      = b[TimerWidth-1:0];
        bit_corrected_i  = bc[0];
        uncorrectable_i  = uc[0];
        err_add_i        = add[AddrWidth-1:0];
        err_way_i        = way[WayWidth-1:0];
        clear_i          = clr[0];
        corr_threshold_i = thr[CntWidth-1:0];
        @(posedge clk_i);
        modelEdge(en, n, b, bc, uc, add, way, clr, thr);
        #1;
        checkAll(tag);
    endtask

    initial begin
        int curEn;
        int curN;
        int curB;
        int curThr;

        rst_i = 1'b1;
        enable_i = 1'b0; interval_i = '0; burst_len_i = '0;
        bit_corrected_i = 1'b0; uncorrectable_i = 1'b0;
        err_add_i = '0; err_way_i = '0; clear_i = 1'b0; corr_threshold_i = '0;
        modelReset();

        // Reset state.
        #12;
        checkAll("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        // N = 3, B = 2 duty cycle from edge E.
        for (int i = 0; i < 12; i++) applyStimulus("n3b2", 1, 3, 2, 0, 0, 0, 0, 0, 0);
        while (mTrig == 0) applyStimulus("n3b2.seek", 1, 3, 2, 0, 0, 0, 0, 0, 0);

        // Reset mid-burst must drop the trigger without waiting for an edge.
        rst_i = 1'b1;
        #1;
        modelReset();
        checkAll("midburst_reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        // N = 0 gives a continuous trigger. Dropping enable clears it one
        // cycle later.
        for (int i = 0; i < 8; i++) applyStimulus("n0b5", 1, 0, 5, 0, 0, 0, 0, 0, 0);
        applyStimulus("n0b5.disable", 0, 0, 5, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus("n2b0", 1, 2, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("idle", 0, 2, 0, 0, 0, 0, 0, 0, 0);

        // 20 corrected pulses saturate the 4-bit counter at 15.
        for (int i = 0; i < 20; i++) applyStimulus("saturate", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("saturate.final", {28'd0, corr_cnt_o}, 15);

        // Threshold 3: irq rises after the third pulse. A clear that
        // coincides with a pulse leaves the count at 1 and the irq low.
        applyStimulus("clear", 0, 0, 0, 0, 0, 0, 0, 1, 3);
        for (int i = 0; i < 3; i++) applyStimulus("thresh", 0, 0, 0, 1, 0, 0, 0, 0, 3);
        checkOutput("thresh.irq", {31'd0, irq_o}, 1);
        applyStimulus("clear_pulse", 0, 0, 0, 1, 0, 0, 0, 1, 3);

        // Two uncorrectable errors: the log keeps the last one.
        applyStimulus("uc1", 0, 0, 0, 0, 1, 'h5A, 1, 0, 0);
        applyStimulus("uc2", 0, 0, 0, 0, 1, 'h10, 0, 0, 0);
        checkOutput("uc.cnt", {28'd0, uncorr_cnt_o}, 2);

        // Pulses while disabled still count, and the trigger stays low.
        for (int i = 0; i < 4; i++) applyStimulus("disabled_pulses", 0, 3, 2, 1, i % 2, i, 1, 0, 0);

        // Randomised traffic. Timing parameters change only while the
        // enable is low.
        curEn = 0; curN = 1; curB = 1; curThr = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 11) == 0) curEn = 1 - curEn;
            if (curEn == 0) begin
                curN = $urandom_range(0, 5);
                curB = $urandom_range(0, 4);
            end
            if ($urandom_range(0, 29) == 0) curThr = $urandom_range(0, 15);
            applyStimulus("random", curEn, curN, curB,
                          ($urandom_range(0, 3) == 0) ? 1 : 0,
                          ($urandom_range(0, 15) == 0) ? 1 : 0,
                          $urandom_range(0, 255), $urandom_range(0, 1),
                          ($urandom_range(0, 39) == 0) ? 1 : 0, curThr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
